// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared encodings for the 4-bit universal shift register and its upstream
// sequencer (usr_shift_controller).
//   - MODE_* : register mode select, common to the controller and the register.
//   - ST_*   : controller FSM state encoding.
//   - shift_mode() : maps a shift direction onto the register mode select.
// -----------------------------------------------------------------------------
package usr_pkg;

  // Register mode select
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // dir = 0 shifts toward the LSB, dir = 1 toward the MSB
  function automatic logic [1:0] shift_mode(input logic dir);
    logic [1:0] m;
    if (dir) begin
      m = MODE_SHL;
    end else begin
      m = MODE_SHR;
    end
    return m;
  endfunction

endpackage

// File: rtl/usr_shift_controller.sv
// -----------------------------------------------------------------------------
// usr_shift_controller
// Sequencer in front of the universal shift register. A request (data word,
// direction, shift count) is taken over a valid/ready handshake; the block then
// drives one parallel-load cycle, exactly shift_cnt shift cycles and a single
// done cycle before returning to idle.
//
// Build option:
//   USR_SHIFT_CTRL_ROTATE_EN  defined   -> the active serial input is fed from
//                                          the register's far end (rotate).
//                             undefined -> the active serial input carries FILL
//                                          and q_lsb / q_msb are ignored.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start_valid     request present
//   start_ready     request can be taken (IDLE and not in reset), combinational
//   data_in         word to load
//   dir             0 = shift right (toward LSB), 1 = shift left
//   shift_cnt       number of shift cycles after the load
//   q_lsb, q_msb    register end bits, used for rotate
//   mode            register mode select (see usr_pkg MODE_*)
//   par_out         parallel-load bus
//   sr_in, sl_in    serial inputs for shift right / shift left
//   busy            high during LOAD and SHIFT
//   done            one-cycle completion pulse
// -----------------------------------------------------------------------------
module usr_shift_controller
  import usr_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter int   CNT_W = 3,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             q_lsb,
  input  logic             q_msb,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] par_out,
  output logic             sr_in,
  output logic             sl_in,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             dir_r;
  logic             dir_nxt_s;
  logic [WIDTH-1:0] par_nxt_s;
  logic [1:0]       mode_nxt_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;

  // Requests are only taken in IDLE; reset masks acceptance in the same cycle
  assign start_ready = (state_r == ST_IDLE) && !rst;

  // Next-state, counter and request-latch logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dir_nxt_s   = dir_r;
    par_nxt_s   = par_out;
    case (state_r)
      ST_IDLE: begin
        // rst has priority in the register process, so start_valid here is an accept
        if (start_valid) begin
          state_nxt_s = ST_LOAD;
          cnt_nxt_s   = shift_cnt;
          dir_nxt_s   = dir;
          par_nxt_s   = data_in;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_r != CNT_ZERO) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_SHIFT: begin
        cnt_nxt_s = cnt_r - CNT_ONE;
        // The cycle that sees a count of one is the last shift
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it
  always_comb begin
    mode_nxt_s = MODE_HOLD;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_LOAD: begin
        mode_nxt_s = MODE_LOAD;
        busy_nxt_s = 1'b1;
      end
      ST_SHIFT: begin
        mode_nxt_s = shift_mode(dir_nxt_s);
        busy_nxt_s = 1'b1;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        mode_nxt_s = MODE_HOLD;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
      par_out <= {WIDTH{1'b0}};
      mode    <= MODE_HOLD;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dir_r   <= dir_nxt_s;
      par_out <= par_nxt_s;
      mode    <= mode_nxt_s;
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
    end
  end

`ifdef USR_SHIFT_CTRL_ROTATE_EN
  logic unused_fill_s;
  assign unused_fill_s = FILL;

  // Rotate: the bit leaving the register re-enters at the opposite end. This
  // path is combinational from q_* so the feedback bit is the current one.
  always_comb begin
    sr_in = 1'b0;
    sl_in = 1'b0;
    if (state_r == ST_SHIFT) begin
      if (dir_r) begin
        sl_in = q_msb;
      end else begin
        sr_in = q_lsb;
      end
    end else begin
      sr_in = 1'b0;
      sl_in = 1'b0;
    end
  end
`else
  logic unused_q_s;
  assign unused_q_s = q_lsb ^ q_msb;

  // Fill: only the serial input of the active direction carries FILL
  always_comb begin
    sr_in = 1'b0;
    sl_in = 1'b0;
    if (state_r == ST_SHIFT) begin
      if (dir_r) begin
        sl_in = FILL;
      end else begin
        sr_in = FILL;
      end
    end else begin
      sr_in = 1'b0;
      sl_in = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_usr_shift_controller.sv
// -----------------------------------------------------------------------------
// tb_usr_shift_controller
// Drives usr_shift_controller into a behavioural universal shift register and
// checks every cycle against a request-level model (a queue of expected
// register operations). Directed sequences add literal end-to-end checks.
// Build with +define+USR_SHIFT_CTRL_ROTATE_EN for the rotate variant.
// -----------------------------------------------------------------------------
module tb_usr_shift_controller;

  localparam int   W    = 4;
  localparam int   CW   = 3;
  localparam logic FILL = 1'b0;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [W-1:0]  data_in = 4'b0000;
  logic          dir = 1'b0;
  logic [CW-1:0] shift_cnt = 3'd0;
  logic          q_lsb;
  logic          q_msb;
  logic [1:0]    mode;
  logic [W-1:0]  par_out;
  logic          sr_in;
  logic          sl_in;
  logic          busy;
  logic          done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  usr_shift_controller #(.WIDTH(W), .CNT_W(CW), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .data_in(data_in), .dir(dir), .shift_cnt(shift_cnt),
    .q_lsb(q_lsb), .q_msb(q_msb), .mode(mode), .par_out(par_out),
    .sr_in(sr_in), .sl_in(sl_in), .busy(busy), .done(done)
  );

  // Behavioural universal shift register driven by the controller
  logic [W-1:0] ureg;
  always @(posedge clk) begin
    if (rst) ureg <= 4'b0000;
    else begin
      case (mode)
        2'b01:   ureg <= {sr_in, ureg[W-1:1]};
        2'b10:   ureg <= {ureg[W-2:0], sl_in};
        2'b11:   ureg <= par_out;
        default: ureg <= ureg;
      endcase
    end
  end
  assign q_lsb = ureg[0];
  assign q_msb = ureg[W-1];

  // Model: each accepted request becomes a list of per-cycle operations
  // {is_done, mode}: load, N shifts, done. Empty list = idle.
  logic [2:0]   ops[$];
  logic [W-1:0] exp_q = 4'b0000;
  logic [W-1:0] m_par = 4'b0000;

  always @(posedge clk) begin
    if (rst) begin
      ops.delete();
      exp_q <= 4'b0000;
      m_par <= 4'b0000;
    end else if (ops.size() == 0) begin
      if (start_valid) begin
        m_par <= data_in;
        ops.push_back(3'b011);
        for (int i = 0; i < int'(shift_cnt); i++)
          ops.push_back(dir ? 3'b010 : 3'b001);
        ops.push_back(3'b100);
      end
    end else begin
      case (ops[0])
        3'b011: exp_q <= m_par;
        3'b001: exp_q <= ROT ? ((exp_q >> 1) | (exp_q << (W-1)))
                             : ((exp_q >> 1) | ({3'b000, FILL} << (W-1)));
        3'b010: exp_q <= ROT ? ((exp_q << 1) | (exp_q >> (W-1)))
                             : ((exp_q << 1) | {3'b000, FILL});
        default: exp_q <= exp_q;
      endcase
      void'(ops.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    logic [2:0] cur;
    forever begin
      @(negedge clk);
      if (checking) begin
        cur = (ops.size() != 0) ? ops[0] : 3'b000;
        check("mode",        {30'd0, mode},     {30'd0, cur[1:0]});
        check("busy",        {31'd0, busy},     {31'd0, (cur[1:0] != 2'b00)});
        check("done",        {31'd0, done},     {31'd0, cur[2]});
        check("start_ready", {31'd0, start_ready}, {31'd0, (ops.size() == 0) && !rst});
        check("sr_in", {31'd0, sr_in}, {31'd0, (cur == 3'b001) ? (ROT ? exp_q[0] : FILL) : 1'b0});
        check("sl_in", {31'd0, sl_in}, {31'd0, (cur == 3'b010) ? (ROT ? exp_q[W-1] : FILL) : 1'b0});
        check("par_out",     {28'd0, par_out},  {28'd0, m_par});
        check("register",    {28'd0, ureg},     {28'd0, exp_q});
      end
    end
  end

  // One request from IDLE; checks done latency and final register literal
  task automatic run_seq(input logic [W-1:0] d, input logic dr, input logic [CW-1:0] n,
                         input logic [W-1:0] exp_reg, input string tag);
    int lat;
    lat = -1;
    @(posedge clk); #2;
    data_in = d; dir = dr; shift_cnt = n; start_valid = 1'b1;
    @(posedge clk); #2;
    start_valid = 1'b0; data_in = ~d; dir = ~dr; shift_cnt = ~n;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, int'(n) + 2);
    check({tag, " final reg"}, {28'd0, ureg}, {28'd0, exp_reg});
  endtask

  initial begin
    int acc;
    int dones;
    @(posedge clk); #1;
    checking = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check("reset mode", {30'd0, mode}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Tests 1-3 plus a count larger than the width
    run_seq(4'b1011, 1'b0, 3'd2, ROT ? 4'b1110 : 4'b0010, "shr2");
    run_seq(4'b1011, 1'b1, 3'd3, ROT ? 4'b1101 : 4'b1000, "shl3");
    run_seq(4'b0110, 1'b0, 3'd0, 4'b0110, "cnt0");
    run_seq(4'b1010, 1'b1, 3'd7, ROT ? 4'b0101 : 4'b0000, "shl7");
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    run_seq(4'b1001, 1'b0, 3'd4, 4'b1001, "rot4");
    run_seq(4'b1001, 1'b0, 3'd1, 4'b1100, "rot1");
`endif

    // start_valid held through two sequences: one accept each
    @(posedge clk); #2;
    data_in = 4'b0011; dir = 1'b0; shift_cnt = 3'd1; start_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (start_valid && start_ready) acc++;
    end
    @(posedge clk); #2;
    start_valid = 1'b0;
    check("held valid accepts", acc, 2);

    // Reset in the second SHIFT cycle of a 5-shift request
    @(posedge clk); #2;
    data_in = 4'b1111; dir = 1'b1; shift_cnt = 3'd5; start_valid = 1'b1;
    @(posedge clk); #2;
    start_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort mode", {30'd0, mode}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort ready", {31'd0, start_ready}, 32'd1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort no done", dones, 0);

    // Reset and start_valid together: request dropped
    @(posedge clk); #2;
    rst = 1'b1; start_valid = 1'b1; shift_cnt = 3'd2;
    @(posedge clk); #2;
    rst = 1'b0; start_valid = 1'b0;
    @(negedge clk);
    check("rst+valid busy", {31'd0, busy}, 32'd0);
    check("rst+valid mode", {30'd0, mode}, 32'd0);

    repeat (3) @(posedge clk);
    #2;
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_shift_controller.md
Name: usr_shift_controller

Overview:
- Upstream control stage for the 4-bit universal shift register.
- Accepts a parallel word plus a shift request over a valid/ready handshake.
- Drives the register's mode select, parallel-load bus and serial inputs: one load cycle, then exactly N shift cycles, then a one-cycle done pulse.
- Replaces hand-toggled mode/serial stimulus with a deterministic sequencer.

Parameters:
- WIDTH, 4: register width in bits; par_out width.
- CNT_W, 3: width of the shift-count request; max request 2**CNT_W-1.
- FILL, 1'b0: bit driven on the active serial input during shifts (non-rotate build).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  request present.
- start_ready  output  1  controller can accept a request.
- data_in  input  WIDTH  word to load.
- dir  input  1  0 = shift right (toward LSB), 1 = shift left.
- shift_cnt  input  CNT_W  number of shift cycles after the load.
- q_lsb  input  1  register bit 0, fed back for rotate.
- q_msb  input  1  register bit WIDTH-1, fed back for rotate.
- mode  output  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- par_out  output  WIDTH  parallel-load bus to the register.
- sr_in  output  1  serial input used on shift right (enters the MSB).
- sl_in  output  1  serial input used on shift left (enters the LSB).
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle pulse when the sequence completes.

Behaviour:

Clocking and reset:
- All state is registered on the rising edge of clk.
- Reset is synchronous and active-high.
- Reset values: state = IDLE, mode = 00, par_out = 0, sr_in = 0, sl_in = 0, busy = 0, done = 0, internal counter = 0.
- start_ready is combinational: high iff state == IDLE and rst == 0.

FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - mode = 00.
  - On start_valid && start_ready: latch data_in→par_out, dir, and shift_cnt→counter; next state LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - mode = 11, busy = 1.
  - Next state is SHIFT if counter != 0, else DONE.
- SHIFT:
  - mode = 01 if dir == 0, 10 if dir == 1. busy = 1.
  - counter decrements each cycle.
  - Leave for DONE after the cycle in which counter == 1, so exactly shift_cnt shift cycles occur.
- DONE (exactly 1 cycle):
  - mode = 00, done = 1, busy = 0.
  - Next state IDLE.

Serial inputs:
- Only the serial input for the active direction carries FILL (or the rotate bit); the other is driven 0.
- Outside SHIFT, both are 0.

Latency:
- Accept at edge k → mode = 11 during cycle k+1 → shifts during cycles k+2 … k+1+N → done during cycle k+2+N.
- Zero-count request: done during cycle k+2.

Boundaries:
- start_valid while busy or in DONE: ignored, no queuing. start_ready is low there.
- Earliest new accept is the cycle after DONE.
- shift_cnt > WIDTH is legal; all shifts are issued (register fills with FILL, or wraps in rotate).
- data_in, dir and shift_cnt changing after accept: no effect.
- rst asserted in any state: at the next edge, return to IDLE with reset values. No done pulse for the aborted sequence.
- rst and start_valid in the same cycle: reset wins, request dropped.

Optional Feature:
- Macro: USR_SHIFT_CTRL_ROTATE_EN.
- Defined: during SHIFT, sr_in = q_lsb when dir == 0, and sl_in = q_msb when dir == 1. The register rotates; after N == WIDTH shifts it holds the original word. FILL is unused.
- Undefined: q_lsb and q_msb are ignored, and the active serial input = FILL.

Decomposition:
- Shared package usr_pkg holds:
  - the mode encoding constants MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11, shared with the shift register;
  - the FSM state encoding.
- No sub-module: a single FSM plus down-counter.
- The bench instantiates this block driving the universal shift register for end-to-end checks.

Test Plan (WIDTH = 4, FILL = 0):
1. Reset, then data_in = 4'b1011, dir = 0, shift_cnt = 2 → mode 11 for 1 cycle, then 01 for 2 cycles, done for 1 cycle. Register = 4'b0010.
2. data_in = 4'b1011, dir = 1, shift_cnt = 3 → mode 10 for 3 cycles. Register = 4'b1000. done at accept + 5 cycles.
3. shift_cnt = 0 → LOAD then DONE directly, no 01/10 cycle. Register = data_in.
4. start_valid held high through a sequence → start_ready low from LOAD through DONE. Exactly one accept per sequence; second accept the cycle after DONE.
5. rst asserted in the 2nd SHIFT cycle of a shift_cnt = 5 request → next edge: mode = 00, busy = 0, start_ready = 1. No done pulse.
6. With USR_SHIFT_CTRL_ROTATE_EN defined: data_in = 4'b1001, dir = 0, shift_cnt = 4 → register returns to 4'b1001. shift_cnt = 1 gives 4'b1100.
